mac32_result_checker: RTL and testbench
=======================================

Name: mac32_result_checker

Overview:
- Synthesizable result checker directly downstream of the mac32 DUT in the baseline bench.
- Stimulus side pushes each expected fp32 result (A + B*C, from the reference model) into an in-order FIFO.
- Each DUT result pops one expected word, is compared with IEEE-754 aware ULP tolerance, and updates pass/fail counters and sticky error flags.
- The bench reads the counters and flags at end of test instead of using ad-hoc $display checks.

Parameters:
- PARM_XLEN, 32, operand/result width.
- PARM_EXP, 8, exponent width.
- PARM_MANT, 23, mantissa width.
- DEPTH, 8, expected-FIFO entries; power of 2, ≥2.
- TOL_ULP, 0, max allowed |expected − got| in ULPs for finite same-sign values.
- ZERO_SIGN_EQ, 1, 1 = +0 and −0 compare equal.
- CNT_W, 16, pass/fail counter width.

Ports:
- clk  in  1  bench clock (mac32_if clk).
- rst_n  in  1  synchronous active-low reset.
- exp_valid_i  in  1  push expected result.
- exp_data_i  in  PARM_XLEN  expected result bits.
- dut_valid_i  in  1  DUT result valid this cycle.
- Result_i  in  PARM_XLEN  DUT Result_o.
- pending_o  out  $clog2(DEPTH)+1  expected entries not yet consumed.
- chk_valid_o  out  1  one-cycle pulse: a comparison completed.
- mismatch_o  out  1  qualifies chk_valid_o; 1 = fail.
- pass_cnt_o  out  CNT_W  passing comparisons, saturating.
- fail_cnt_o  out  CNT_W  failing comparisons, saturating.
- first_exp_o  out  PARM_XLEN  expected value of first failure.
- first_got_o  out  PARM_XLEN  DUT value of first failure.
- overflow_o  out  1  sticky: push while FIFO full.
- orphan_o  out  1  sticky: dut_valid_i while FIFO empty.

Behaviour:
- All state is on posedge clk. Reset takes priority over every other event and applies even mid-operation.
- Reset values: every output 0, FIFO empty, pointers 0, pipeline valid bits cleared. An in-flight comparison is discarded and not counted.
- FIFO ordering: strict in-order. Empty/full are judged on occupancy at the start of the cycle.
- Push while full: data dropped; overflow_o set; the pop (if any) still proceeds.
- Pop while empty: orphan_o set; no comparison; no counter change. A same-cycle push into an empty FIFO is not bypassed; it is stored normally.
- Simultaneous push and pop on a non-empty, non-full FIFO: both occur; occupancy unchanged.
- Pointers wrap modulo DEPTH. pending_o reflects occupancy after the cycle's push/pop.
- Pipeline stage S1 (cycle after pop): register {exp, got, valid}.
- Pipeline stage S2: compare and register results. chk_valid_o, mismatch_o, and counter/capture updates become visible 2 cycles after the dut_valid_i edge. Throughput is 1 result per cycle.
- Compare rules, in priority order:
  - exp NaN (exponent all 1s, mantissa ≠0): pass iff got is any NaN.
  - exp ±Inf: pass iff got has identical bits.
  - both zero (magnitude 0): pass iff signs equal, or ZERO_SIGN_EQ=1.
  - signs differ: fail.
  - otherwise: diff = |exp[30:0] − got[30:0]| as unsigned 31-bit; pass iff diff ≤ TOL_ULP.
  - got NaN/Inf against finite exp: fail.
- Counters: pass_cnt_o or fail_cnt_o increments by 1 per completed comparison and saturates at all-ones.
- First-failure capture: first_exp_o/first_got_o load on the first failure since reset only, then hold.
- Sticky flags (overflow_o, orphan_o) clear only on reset.

Test Plan:
- Push exp 0x40F00000 (1.5+2.0*3.0=7.5); 1 cycle later dut_valid_i with Result_i=0x40F00000 → 2 cycles later chk_valid_o=1, mismatch_o=0, pass_cnt_o=1, pending_o=0.
- TOL_ULP=1: exp 0x40F00000, got 0x40F00001 → pass. With TOL_ULP=0 → mismatch_o=1, fail_cnt_o=1, first_exp_o=0x40F00000, first_got_o=0x40F00001. A second failure 0x3F800000 vs 0x3F800002 leaves the capture unchanged.
- Special values: exp 0x7FC00000 vs got 0x7FC00001 → pass. exp 0x7F800000 vs got 0x7F7FFFFF with TOL_ULP=1 → fail. exp 0x00000000 vs got 0x80000000 → pass if ZERO_SIGN_EQ=1, fail if 0.
- Ordering/back-to-back: push 4 expected values in 4 cycles, then return 4 DUT results on consecutive cycles (3rd wrong) → 4 chk_valid_o pulses on consecutive cycles; only the 3rd has mismatch_o; pass_cnt_o=3, fail_cnt_o=1.
- Boundaries: DEPTH+1 pushes with no pops → overflow_o=1, pending_o=DEPTH. dut_valid_i on empty FIFO (including a same-cycle push) → orphan_o=1, counters unchanged, pending_o=1 afterwards.
- Reset mid-operation: drive rst_n=0 one cycle after a pop → no chk_valid_o pulse; all outputs read 0 the cycle after reset; a subsequent normal transaction passes with pass_cnt_o=1.

Source files
------------

// File: rtl/mac32_result_checker_if.sv
// Interface bundle for the mac32 result checker: expected-value push side,
// DUT result side and the checker's status outputs.
interface mac32_result_checker_if #(
  parameter int PARM_XLEN = 32,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 16
);
  logic                   exp_valid_i;
  logic [PARM_XLEN-1:0]   exp_data_i;
  logic                   dut_valid_i;
  logic [PARM_XLEN-1:0]   Result_i;
  logic [$clog2(DEPTH):0] pending_o;
  logic                   chk_valid_o;
  logic                   mismatch_o;
  logic [CNT_W-1:0]       pass_cnt_o;
  logic [CNT_W-1:0]       fail_cnt_o;
  logic [PARM_XLEN-1:0]   first_exp_o;
  logic [PARM_XLEN-1:0]   first_got_o;
  logic                   overflow_o;
  logic                   orphan_o;

  modport slave (
    input  exp_valid_i, exp_data_i, dut_valid_i, Result_i,
    output pending_o, chk_valid_o, mismatch_o, pass_cnt_o, fail_cnt_o,
           first_exp_o, first_got_o, overflow_o, orphan_o
  );

  modport master (
    output exp_valid_i, exp_data_i, dut_valid_i, Result_i,
    input  pending_o, chk_valid_o, mismatch_o, pass_cnt_o, fail_cnt_o,
           first_exp_o, first_got_o, overflow_o, orphan_o
  );
endinterface

// File: rtl/mac32_result_checker.sv
// In-order expected-result FIFO followed by a two-stage IEEE-754 aware
// comparator with saturating pass/fail counters and first-failure capture.
module mac32_result_checker #(
  parameter int PARM_XLEN    = 32,
  parameter int PARM_EXP     = 8,
  parameter int PARM_MANT    = 23,
  parameter int DEPTH        = 8,
  parameter int TOL_ULP      = 0,
  parameter int ZERO_SIGN_EQ = 1,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst_n,
  mac32_result_checker_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int MW = PARM_XLEN - 1;

  logic [PARM_XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 full, empty, do_push, do_pop;
  logic                 overflow, orphan;

  logic                 s1_valid;
  logic [PARM_XLEN-1:0] s1_exp, s1_got;

  logic                 chk_valid, mismatch;
  logic [CNT_W-1:0]     pass_cnt, fail_cnt;
  logic [PARM_XLEN-1:0] first_exp, first_got;

  logic [PARM_EXP-1:0]  e_exp, g_exp;
  logic [PARM_MANT-1:0] e_man, g_man;
  logic [MW-1:0]        e_mag, g_mag, diff;
  logic                 e_nan, e_inf, g_nan, g_special, fail_now;

  // Full/empty come from occupancy at the start of the cycle, so a push
  // into an empty FIFO is never bypassed to a same-cycle pop.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = bus.exp_valid_i && !full;
  assign do_pop  = bus.dut_valid_i && !empty;

  always_ff @(posedge clk) begin
    if (rst_n && do_push)
      mem[wr_ptr] <= bus.exp_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      orphan   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (bus.exp_valid_i && full)  overflow <= 1'b1;
      if (bus.dut_valid_i && empty) orphan   <= 1'b1;
    end
  end

  // A non-finite DUT result never matches a finite expectation, even when
  // the raw bit distance would fall inside the ULP tolerance.
  always_comb begin
    e_exp     = s1_exp[PARM_XLEN-2 -: PARM_EXP];
    g_exp     = s1_got[PARM_XLEN-2 -: PARM_EXP];
    e_man     = s1_exp[PARM_MANT-1:0];
    g_man     = s1_got[PARM_MANT-1:0];
    e_mag     = s1_exp[MW-1:0];
    g_mag     = s1_got[MW-1:0];
    e_nan     = (&e_exp) && (|e_man);
    e_inf     = (&e_exp) && !(|e_man);
    g_special = &g_exp;
    g_nan     = g_special && (|g_man);
    diff      = (e_mag >= g_mag) ? (e_mag - g_mag) : (g_mag - e_mag);
    fail_now  = 1'b0;
    if (e_nan)
      fail_now = !g_nan;
    else if (e_inf)
      fail_now = (s1_got != s1_exp);
    else if (e_mag == '0 && g_mag == '0)
      fail_now = (s1_exp[MW] != s1_got[MW]) && (ZERO_SIGN_EQ == 0);
    else if (s1_exp[MW] != s1_got[MW])
      fail_now = 1'b1;
    else if (g_special)
      fail_now = 1'b1;
    else
      fail_now = (diff > MW'(TOL_ULP));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_exp    <= '0;
      s1_got    <= '0;
      chk_valid <= 1'b0;
      mismatch  <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      first_exp <= '0;
      first_got <= '0;
    end else begin
      s1_valid <= do_pop;
      if (do_pop) begin
        s1_exp <= mem[rd_ptr];
        s1_got <= bus.Result_i;
      end
      chk_valid <= s1_valid;
      mismatch  <= s1_valid && fail_now;
      if (s1_valid) begin
        if (fail_now) begin
          if (fail_cnt == '0) begin
            first_exp <= s1_exp;
            first_got <= s1_got;
          end
          if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        end else if (pass_cnt != '1) begin
          pass_cnt <= pass_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.pending_o   = count;
  assign bus.chk_valid_o = chk_valid;
  assign bus.mismatch_o  = mismatch;
  assign bus.pass_cnt_o  = pass_cnt;
  assign bus.fail_cnt_o  = fail_cnt;
  assign bus.first_exp_o = first_exp;
  assign bus.first_got_o = first_got;
  assign bus.overflow_o  = overflow;
  assign bus.orphan_o    = orphan;
endmodule

// File: tb/tb_mac32_result_checker.sv
// Scoreboard bench: two checker instances (TOL_ULP=0/ZERO_SIGN_EQ=1 and
// TOL_ULP=1/ZERO_SIGN_EQ=0) share stimulus; a monitor pops expected verdicts.
module tb_mac32_result_checker;
  logic clk;
  logic rst_n;
  int   nChecks = 0;
  int   nFails  = 0;
  int   mCount  = 0;

  typedef struct {
    logic m0;
    logic m1;
  } verdict_t;
  verdict_t sb[$];

  mac32_result_checker_if #(.PARM_XLEN(32), .DEPTH(8), .CNT_W(16)) if0 ();
  mac32_result_checker_if #(.PARM_XLEN(32), .DEPTH(8), .CNT_W(16)) if1 ();

  mac32_result_checker #(.DEPTH(8), .TOL_ULP(0), .ZERO_SIGN_EQ(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  mac32_result_checker #(.DEPTH(8), .TOL_ULP(1), .ZERO_SIGN_EQ(0), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic driveInputs(input logic ev, input logic [31:0] ed, input logic dv, input logic [31:0] res);
    if0.exp_valid_i = ev; if0.exp_data_i = ed; if0.dut_valid_i = dv; if0.Result_i = res;
    if1.exp_valid_i = ev; if1.exp_data_i = ed; if1.dut_valid_i = dv; if1.Result_i = res;
  endtask

  // One clock of stimulus; a pop that the FIFO can honour queues its verdicts.
  task automatic applyStimulus(input logic ev, input logic [31:0] ed, input logic dv,
                               input logic [31:0] res, input logic m0, input logic m1);
    bit pushOk, popOk;
    pushOk = ev && (mCount < 8);
    popOk  = dv && (mCount > 0);
    if (popOk) sb.push_back('{m0: m0, m1: m1});
    mCount = mCount + int'(pushOk) - int'(popOk);
    driveInputs(ev, ed, dv, res);
    @(posedge clk); #1;
    driveInputs(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    sb.delete();
    mCount = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_pending"},   32'(if0.pending_o), 0);
    checkOutput({tag, "_chk"},       32'(if0.chk_valid_o), 0);
    checkOutput({tag, "_mismatch"},  32'(if0.mismatch_o), 0);
    checkOutput({tag, "_pass"},      32'(if0.pass_cnt_o), 0);
    checkOutput({tag, "_fail"},      32'(if0.fail_cnt_o), 0);
    checkOutput({tag, "_first_exp"}, if0.first_exp_o, 0);
    checkOutput({tag, "_first_got"}, if0.first_got_o, 0);
    checkOutput({tag, "_overflow"},  32'(if0.overflow_o), 0);
    checkOutput({tag, "_orphan"},    32'(if0.orphan_o), 0);
    checkOutput({tag, "_fail1"},     32'(if1.fail_cnt_o), 0);
  endtask

  // Monitor: every chk_valid pulse consumes one queued verdict.
  always @(negedge clk) begin
    verdict_t v;
    if (if0.chk_valid_o === 1'b1 || if1.chk_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpected_chk: got chk0=%0b chk1=%0b, expected no pulse",
                 if0.chk_valid_o, if1.chk_valid_o);
      end else begin
        v = sb.pop_front();
        checkOutput("mon_chk0", 32'(if0.chk_valid_o), 1);
        checkOutput("mon_chk1", 32'(if1.chk_valid_o), 1);
        checkOutput("mon_mismatch0", 32'(if0.mismatch_o), 32'(v.m0));
        checkOutput("mon_mismatch1", 32'(if1.mismatch_o), 32'(v.m1));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    driveInputs(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkAllZero("reset");

    // 1.5 + 2.0*3.0 = 7.5 exact match
    applyStimulus(1'b1, 32'h40F00000, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("pending_after_push", 32'(if0.pending_o), 1);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h40F00000, 1'b0, 1'b0);
    idle(3);
    checkOutput("basic_pass0", 32'(if0.pass_cnt_o), 1);
    checkOutput("basic_pass1", 32'(if1.pass_cnt_o), 1);
    checkOutput("basic_pending", 32'(if0.pending_o), 0);

    // One ULP off: fails at tolerance 0, passes at tolerance 1
    applyStimulus(1'b1, 32'h40F00000, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h40F00001, 1'b1, 1'b0);
    idle(3);
    checkOutput("ulp_fail0", 32'(if0.fail_cnt_o), 1);
    checkOutput("ulp_first_exp0", if0.first_exp_o, 32'h40F00000);
    checkOutput("ulp_first_got0", if0.first_got_o, 32'h40F00001);
    checkOutput("ulp_pass1", 32'(if1.pass_cnt_o), 2);
    checkOutput("ulp_fail1", 32'(if1.fail_cnt_o), 0);

    // Two ULPs off: both fail; instance 0 keeps its earlier capture
    applyStimulus(1'b1, 32'h3F800000, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h3F800002, 1'b1, 1'b1);
    idle(3);
    checkOutput("second_fail0", 32'(if0.fail_cnt_o), 2);
    checkOutput("hold_first_exp0", if0.first_exp_o, 32'h40F00000);
    checkOutput("hold_first_got0", if0.first_got_o, 32'h40F00001);
    checkOutput("first_exp1", if1.first_exp_o, 32'h3F800000);
    checkOutput("first_got1", if1.first_got_o, 32'h3F800002);

    // Special values: NaN, Inf, signed zero, Inf result vs finite
    applyStimulus(1'b1, 32'h7FC00000, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h7FC00001, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h7F800000, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h7F7FFFFF, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h00000000, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h80000000, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h7F7FFFFF, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h7F800000, 1'b1, 1'b1);
    idle(3);
    checkOutput("special_pass0", 32'(if0.pass_cnt_o), 3);
    checkOutput("special_fail0", 32'(if0.fail_cnt_o), 4);
    checkOutput("special_pass1", 32'(if1.pass_cnt_o), 3);
    checkOutput("special_fail1", 32'(if1.fail_cnt_o), 4);

    // Back-to-back ordering, third result wrong by 5 ULPs
    applyStimulus(1'b1, 32'h3F800000, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h40000000, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h40400000, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h40800000, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("b2b_pending", 32'(if0.pending_o), 4);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h3F800000, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h40000000, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h40400005, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h40800000, 1'b0, 1'b0);
    idle(3);
    checkOutput("b2b_pass0", 32'(if0.pass_cnt_o), 6);
    checkOutput("b2b_fail0", 32'(if0.fail_cnt_o), 5);
    checkOutput("b2b_pass1", 32'(if1.pass_cnt_o), 6);
    checkOutput("b2b_fail1", 32'(if1.fail_cnt_o), 5);

    // Overflow: DEPTH+1 pushes with no pops
    doReset();
    for (int i = 0; i < 9; i++)
      applyStimulus(1'b1, 32'h3F800000 + 32'(i), 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("ovf_flag", 32'(if0.overflow_o), 1);
    checkOutput("ovf_pending", 32'(if0.pending_o), 8);
    checkOutput("ovf_orphan", 32'(if0.orphan_o), 0);

    // Orphan pop on empty FIFO with a same-cycle push that must be stored
    doReset();
    checkOutput("orphan_clear", 32'(if0.orphan_o), 0);
    applyStimulus(1'b1, 32'h3F800000, 1'b1, 32'h12345678, 1'b0, 1'b0);
    idle(2);
    checkOutput("orphan_flag", 32'(if0.orphan_o), 1);
    checkOutput("orphan_pending", 32'(if0.pending_o), 1);
    checkOutput("orphan_pass", 32'(if0.pass_cnt_o), 0);
    checkOutput("orphan_fail", 32'(if0.fail_cnt_o), 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h3F800000, 1'b0, 1'b0);
    idle(3);
    checkOutput("stored_pass0", 32'(if0.pass_cnt_o), 1);
    checkOutput("stored_pass1", 32'(if1.pass_cnt_o), 1);

    // Reset one cycle after a pop discards the in-flight comparison
    applyStimulus(1'b1, 32'h40F00000, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h00000001, 1'b1, 1'b1);
    doReset();
    checkAllZero("midreset");
    idle(2);
    checkOutput("midreset_fail0", 32'(if0.fail_cnt_o), 0);
    applyStimulus(1'b1, 32'h40F00000, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h40F00000, 1'b0, 1'b0);
    idle(3);
    checkOutput("post_reset_pass0", 32'(if0.pass_cnt_o), 1);
    checkOutput("post_reset_pass1", 32'(if1.pass_cnt_o), 1);

    idle(2);
    checkOutput("scoreboard_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
